// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit encoding plus the LSU issue-scheduler
// state enum and the memory-op classifier used by the reorder stage.
package ariane_pkg;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC, CVXIF, ACCEL
  } fu_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEFER = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } lsu_sched_state_e;

  function automatic logic is_mem_fu(fu_t fu);
    return (fu == LOAD) || (fu == STORE);
  endfunction

endpackage

// File: rtl/lsu_issue_scheduler_if.sv
// Handshake bundle between the issue/reorder stage, the LSU and the scheduler.
interface lsu_issue_scheduler_if #(
  parameter int unsigned CNT_W = 2
);
  import ariane_pkg::*;

  logic             flush_i;
  logic             debug_req_i;
  fu_t              issue_fu_i;
  logic             issue_valid_i;
  logic             issue_ack_i;
  logic             lsu_ready_i;
  logic             mem_done_i;
  logic             mem_defer_o;
  logic             mem_stall_o;
  logic [CNT_W-1:0] outstanding_o;
  logic [1:0]       state_o;

  modport master (
    output flush_i, debug_req_i, issue_fu_i, issue_valid_i, issue_ack_i,
           lsu_ready_i, mem_done_i,
    input  mem_defer_o, mem_stall_o, outstanding_o, state_o
  );

  modport slave (
    input  flush_i, debug_req_i, issue_fu_i, issue_valid_i, issue_ack_i,
           lsu_ready_i, mem_done_i,
    output mem_defer_o, mem_stall_o, outstanding_o, state_o
  );

endinterface

// File: rtl/updown_sat_counter.sv
// Up/down counter clamped to [0, MAX]; simultaneous inc and dec cancel out.
module updown_sat_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX_V)) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/lsu_issue_scheduler.sv
// Decides when the head memory op is deferred, when memory issue is blocked,
// and drains in-flight LSU traffic while a debug request is pending.
module lsu_issue_scheduler
  import ariane_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 2,
  parameter  int unsigned MAX_DEFER       = 3,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lsu_issue_scheduler_if.slave  bus
);

  localparam int unsigned      DEF_W    = $clog2(MAX_DEFER + 1);
  localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);
  localparam logic [DEF_W-1:0] DEF_LAST = DEF_W'(MAX_DEFER - 1);

  lsu_sched_state_e state_q, state_d;
  logic             mem_head, issue_evt, stall_release;
  logic [CNT_W-1:0] out_q;
  logic [DEF_W-1:0] def_q;

  assign mem_head  = bus.issue_valid_i && is_mem_fu(bus.issue_fu_i);
  assign issue_evt = mem_head && bus.issue_ack_i;

  // Next outstanding drops below the limit only on a completion without a new issue.
  assign stall_release = (out_q < OUT_MAX) || (bus.mem_done_i && !issue_evt);

  updown_sat_counter #(.WIDTH(CNT_W), .MAX(MAX_OUTSTANDING)) u_outstanding (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (issue_evt),
    .dec   (bus.mem_done_i),
    .clr   (bus.flush_i),
    .count (out_q)
  );

  // Saturating at MAX_DEFER locks out re-deferral until the op finally issues.
  updown_sat_counter #(.WIDTH(DEF_W), .MAX(MAX_DEFER)) u_defer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (state_q == DEFER),
    .dec   (1'b0),
    .clr   (bus.flush_i || issue_evt),
    .count (def_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.debug_req_i)                                       state_d = DRAIN;
          else if (mem_head && (out_q == OUT_MAX))                   state_d = STALL;
          else if (mem_head && !bus.lsu_ready_i && (def_q < DEF_MAX)) state_d = DEFER;
        end
        DEFER: begin
          if (bus.debug_req_i) state_d = DRAIN;
          else if (bus.lsu_ready_i || !mem_head || issue_evt || (def_q == DEF_LAST))
            state_d = IDLE;
        end
        STALL: begin
          if (bus.debug_req_i)  state_d = DRAIN;
          else if (stall_release) state_d = IDLE;
        end
        DRAIN: begin
          if (!bus.debug_req_i && (out_q == '0)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_defer_o   = (state_q == DEFER);
  assign bus.mem_stall_o   = (state_q == STALL) || (state_q == DRAIN);
  assign bus.outstanding_o = out_q;
  assign bus.state_o       = state_q;

  // Protocol checks; a flush cycle discards completions, so it is exempt.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !bus.flush_i) begin
      assert (!(bus.mem_done_i && (out_q == '0)));
      assert (!(issue_evt && (out_q == OUT_MAX)));
    end
  end

endmodule

// File: doc/lsu_issue_scheduler.md
# lsu_issue_scheduler

Controller that sequences memory-operation issue toward the LSU. It sits beside the issue-stage reorder buffer slot and watches the head instruction's functional unit, the LSU's readiness and LSU completions. From these it tells the reorder stage when to defer a load/store so an independent instruction can overtake it, and when to block memory issue outright because too many memory ops are in flight. It also drains memory traffic when a debug request is pending.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: maximum in-flight memory ops (issued, not yet completed); ≥1.
- MAX_DEFER, 3: maximum consecutive cycles one memory op may be deferred; ≥1.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter (derived, not overridden).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush.
- debug_req_i  in  1  debug request pending.
- issue_fu_i  in  ariane_pkg::fu_t  FU of the head instruction presented to issue.
- issue_valid_i  in  1  head instruction valid.
- issue_ack_i  in  1  issue stage consumed the head this cycle.
- lsu_ready_i  in  1  LSU can accept an op.
- mem_done_i  in  1  LSU retired one memory op this cycle (at most one per cycle).
- mem_defer_o  out  1  reorder stage holds the head memory op and lets one independent instruction pass.
- mem_stall_o  out  1  no memory op may be acked this cycle.
- outstanding_o  out  CNT_W  current in-flight memory op count.
- state_o  out  2  current FSM state, for performance counters.

## Operation
- A memory op is issue_fu_i ∈ {LOAD, STORE}. An issue event is issue_valid_i & issue_ack_i & memory op.
- Outstanding counter: +1 on issue event, −1 on mem_done_i. Both in the same cycle: unchanged. mem_done_i at 0: ignored (assertion fires). An issue event at MAX_OUTSTANDING is a protocol violation (assertion fires) and the counter saturates.
- Defer counter (range 0..MAX_DEFER): +1 each cycle in DEFER; reset to 0 on an issue event; otherwise holds. It saturates at MAX_DEFER, so the same op cannot be deferred again until it issues.
- FSM states: IDLE=0, DEFER=1, STALL=2, DRAIN=3.
  - IDLE: If debug_req_i, go to DRAIN. Else if a valid memory op is at the head and outstanding==MAX_OUTSTANDING, go to STALL. Else if a valid memory op is at the head, !lsu_ready_i and defer counter < MAX_DEFER, go to DEFER. Otherwise stay.
  - DEFER: If debug_req_i, go to DRAIN. Else go to IDLE on lsu_ready_i, on the head no longer being a valid memory op, on an issue event, or when the defer counter reaches MAX_DEFER−1 this cycle.
  - STALL: If debug_req_i, go to DRAIN. Else go to IDLE when the next outstanding value is < MAX_OUTSTANDING.
  - DRAIN: Go to IDLE when !debug_req_i and outstanding==0.
- Outputs are Moore-decoded from the registered state.
  - mem_defer_o = (state==DEFER).
  - mem_stall_o = (state==STALL) | (state==DRAIN).
- flush_i: next state IDLE, outstanding and defer counter set to 0. mem_done_i in the flush cycle is discarded. flush_i has priority over debug_req_i for that cycle.
- Priority: rst_i > flush_i > debug_req_i > STALL condition > DEFER condition.

## Timing
- Reset and flush values: state IDLE, mem_defer_o=0, mem_stall_o=0, outstanding_o=0, state_o=0.
- Latency from input condition to output change is 1 cycle. Combinational paths from inputs to outputs: none.
- outstanding_o reflects events up to and including the previous cycle.
- Worst-case deferral of one op is MAX_DEFER cycles; after that the op issues as soon as the LSU accepts it.
- A debug request at any time takes effect on mem_stall_o in the next cycle. Ops already in flight still complete and decrement the counter.

## Structure
- ariane_pkg gains two items:
  - enum lsu_sched_state_e {IDLE, DEFER, STALL, DRAIN} (2 bits).
  - function is_mem_fu(fu_t), returning 1 for LOAD or STORE. The reorder stage uses the same function.
- One sub-module: updown_sat_counter (parameters WIDTH, MAX; inputs inc, dec, clr; saturates at 0 and MAX). It is instantiated for both the outstanding counter and the defer counter; the defer counter ties dec to 0.
- The FSM, next-state logic and assertions live in lsu_issue_scheduler.

## Test plan
- Reset for 2 cycles, then idle inputs → all outputs 0, state_o=0 for 10 cycles.
- Head=LOAD, valid, lsu_ready_i=0 held, no ack → mem_defer_o=1 for exactly 3 cycles starting cycle+1, then 0 and never reasserted until the op issues; lsu_ready_i=1 and ack → defer counter cleared.
- Issue 2 STOREs with ack and no mem_done_i, third STORE at head → outstanding_o=2, mem_stall_o=1 next cycle; a single mem_done_i pulse → outstanding_o=1, mem_stall_o=0 one cycle later.
- Issue event and mem_done_i in the same cycle at outstanding=1 → outstanding_o stays 1, state unchanged.
- debug_req_i=1 while in DEFER with outstanding=2 → mem_defer_o=0, mem_stall_o=1 next cycle; two mem_done_i pulses, then debug_req_i=0 → IDLE one cycle after both conditions hold.
- flush_i while in STALL with outstanding=2 and mem_done_i=1 → next cycle IDLE, outstanding_o=0, all outputs 0.
